// File: rtl/uart_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART frame transmitter and the RX parser:
//   - state_t            : frame sequencer states
//   - SOF_BYTE_DEFAULT   : default start-of-frame marker
//   - ESC_BYTE_DEFAULT   : default escape marker
//   - ESC_XOR            : mask applied to the byte that follows an escape
//   - crc8_step()        : one byte of CRC-8, MSB first, no reflection
// ----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_TYPE,
    ST_PAYLOAD,
    ST_CRC,
    ST_ESC
  } state_t;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] ESC_BYTE_DEFAULT = 8'h5A;
  localparam logic [7:0] ESC_XOR          = 8'h20;

  // Fold one data byte into the running CRC, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_accum.sv
// ----------------------------------------------------------------------------
// crc8_accum
// Registered CRC-8 accumulator.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (loads INIT)
//   clear : reload INIT; wins over en
//   en    : fold data into the CRC this cycle
//   data  : byte to fold
//   crc   : current CRC value
// ----------------------------------------------------------------------------
module crc8_accum
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= INIT;
    end else if (clear) begin
      crc_reg <= INIT;
    end else if (en) begin
      crc_reg <= crc8_step(crc_reg, data, POLY);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/uart_frame_tx_stream.sv
// ----------------------------------------------------------------------------
// uart_frame_tx_stream
// Streams SOF | LEN | TYPE | PAYLOAD | CRC8 to a UART TX byte interface.
// Header (len, type) is taken in one handshake, payload bytes stream through
// one at a time; the CRC is accumulated on the fly over the unescaped bytes.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   hdr_valid/hdr_ready    : header handshake, hdr_len / hdr_type
//   pl_valid/pl_ready      : payload handshake, pl_byte
//   tx_valid/tx_ready      : registered output byte handshake, tx_byte
//   busy                   : frame in progress or output byte pending
//   err_len                : one-cycle pulse on a rejected oversize header
//   frames_sent            : completed frame counter, wraps
// ----------------------------------------------------------------------------
module uart_frame_tx_stream
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 255,
  parameter logic [7:0] SOF_BYTE    = SOF_BYTE_DEFAULT,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00,
  parameter bit         ESCAPE_EN   = 1'b0,
  parameter logic [7:0] ESC_BYTE    = ESC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  hdr_len,
  input  logic [7:0]  hdr_type,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [7:0]  pl_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        err_len,
  output logic [15:0] frames_sent
);

  localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD);

  state_t      state_reg, state_next;
  state_t      ret_reg, ret_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  type_reg, type_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  esc_hold_reg, esc_hold_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [7:0]  tx_byte_reg, tx_byte_next;
  logic        last_reg, last_next;     // byte in the output register ends the frame
  logic        err_len_reg, err_len_next;
  logic [15:0] frames_reg;

  logic        crc_clear, crc_en;
  logic [7:0]  crc_data, crc_val;

  logic        load_ok, hdr_fire, pl_fire;
  logic        emit;
  logic [7:0]  emit_byte;
  state_t      emit_ns;

  function automatic logic needs_esc(input logic [7:0] b);
    return ESCAPE_EN && ((b == SOF_BYTE) || (b == ESC_BYTE));
  endfunction

  crc8_accum #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .data  (crc_data),
    .crc   (crc_val)
  );

  assign load_ok   = !tx_valid_reg || tx_ready;
  // Gated with rst so the readies are low while reset is held.
  assign hdr_ready = !rst && (state_reg == ST_IDLE) && !tx_valid_reg;
  assign pl_ready  = !rst && (state_reg == ST_PAYLOAD) && load_ok;
  assign hdr_fire  = hdr_valid && hdr_ready;
  assign pl_fire   = pl_valid && pl_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ret_reg      <= ST_IDLE;
      len_reg      <= 8'd0;
      type_reg     <= 8'd0;
      idx_reg      <= 8'd0;
      esc_hold_reg <= 8'd0;
      tx_valid_reg <= 1'b0;
      tx_byte_reg  <= 8'd0;
      last_reg     <= 1'b0;
      err_len_reg  <= 1'b0;
      frames_reg   <= 16'd0;
    end else begin
      state_reg    <= state_next;
      ret_reg      <= ret_next;
      len_reg      <= len_next;
      type_reg     <= type_next;
      idx_reg      <= idx_next;
      esc_hold_reg <= esc_hold_next;
      tx_valid_reg <= tx_valid_next;
      tx_byte_reg  <= tx_byte_next;
      last_reg     <= last_next;
      err_len_reg  <= err_len_next;
      if (tx_valid_reg && tx_ready && last_reg) begin
        frames_reg <= frames_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ret_next      = ret_reg;
    len_next      = len_reg;
    type_next     = type_reg;
    idx_next      = idx_reg;
    esc_hold_next = esc_hold_reg;
    // A transferred byte leaves the register empty unless something reloads it.
    tx_valid_next = tx_valid_reg && !tx_ready;
    tx_byte_next  = tx_byte_reg;
    last_next     = last_reg;
    err_len_next  = 1'b0;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;
    crc_data      = 8'd0;
    emit          = 1'b0;
    emit_byte     = 8'd0;
    emit_ns       = state_reg;

    case (state_reg)
      ST_IDLE: begin
        if (hdr_fire) begin
          len_next  = hdr_len;
          type_next = hdr_type;
          idx_next  = 8'd0;
          crc_clear = 1'b1;
          if ({1'b0, hdr_len} > MAX_LEN) begin
            err_len_next = 1'b1;
          end else begin
            // The output register is known empty here, so SOF is loaded on
            // the accepting edge to give a one-cycle header-to-SOF latency.
            tx_valid_next = 1'b1;
            tx_byte_next  = SOF_BYTE;
            last_next     = 1'b0;
            state_next    = ST_LEN;
          end
        end
      end
      ST_SOF: begin
        if (load_ok) begin
          tx_valid_next = 1'b1;
          tx_byte_next  = SOF_BYTE;
          last_next     = 1'b0;
          state_next    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_byte = len_reg;
          emit_ns   = ST_TYPE;
        end
      end
      ST_TYPE: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_byte = type_reg;
          emit_ns   = (len_reg == 8'd0) ? ST_CRC : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pl_fire) begin
          emit      = 1'b1;
          emit_byte = pl_byte;
          idx_next  = idx_reg + 8'd1;
          emit_ns   = ((idx_reg + 8'd1) == len_reg) ? ST_CRC : ST_PAYLOAD;
        end
      end
      ST_CRC: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_byte = crc_val;
          emit_ns   = ST_IDLE;
        end
      end
      ST_ESC: begin
        if (load_ok) begin
          tx_valid_next = 1'b1;
          tx_byte_next  = esc_hold_reg;
          last_next     = (ret_reg == ST_IDLE);
          state_next    = ret_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Common load path for every byte that may need stuffing. The CRC sees
    // the raw byte; the CRC byte itself is never folded.
    if (emit) begin
      tx_valid_next = 1'b1;
      if (state_reg != ST_CRC) begin
        crc_en   = 1'b1;
        crc_data = emit_byte;
      end
      if (needs_esc(emit_byte)) begin
        tx_byte_next  = ESC_BYTE;
        esc_hold_next = emit_byte ^ ESC_XOR;
        ret_next      = emit_ns;
        state_next    = ST_ESC;
        last_next     = 1'b0;
      end else begin
        tx_byte_next  = emit_byte;
        state_next    = emit_ns;
        last_next     = (emit_ns == ST_IDLE);
      end
    end
  end

  assign tx_valid    = tx_valid_reg;
  assign tx_byte     = tx_byte_reg;
  assign busy        = (state_reg != ST_IDLE) || tx_valid_reg;
  assign err_len     = err_len_reg;
  assign frames_sent = frames_reg;

endmodule
